// File: rtl/regfile_2r1w.sv
// Parametrised 2-read / 1-write register file with synchronous clear,
// optional write-to-read forwarding and optional registered read ports.
module regfile_2r1w #(
   parameter int unsigned      NUM_REGS  = 8,
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               BYPASS    = 1'b0,
   parameter bit               READ_REG  = 1'b0,
   localparam int unsigned     AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write,
   input  logic [AW-1:0]    writenum,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AW-1:0]    readnum_a,
   input  logic [AW-1:0]    readnum_b,
   output logic [WIDTH-1:0] data_out_a,
   output logic [WIDTH-1:0] data_out_b
);

   // One extra bit so NUM_REGS itself is representable when it is a power of two.
   localparam int unsigned CW         = AW + 1;
   localparam logic [CW-1:0] NUM_REGS_C = CW'(NUM_REGS);

   logic [WIDTH-1:0] mem [NUM_REGS];

   logic             wr_ok;
   logic             ra_ok;
   logic             rb_ok;
   logic             wr_en;
   logic             fwd_a;
   logic             fwd_b;
   logic [WIDTH-1:0] v_a;
   logic [WIDTH-1:0] v_b;

   function automatic logic addr_ok(input logic [AW-1:0] addr);
      return ({1'b0, addr} < NUM_REGS_C);
   endfunction

   assign wr_ok = addr_ok(writenum);
   assign ra_ok = addr_ok(readnum_a);
   assign rb_ok = addr_ok(readnum_b);
   assign wr_en = write && wr_ok;

   // Forwarding only applies to a write that will actually land this edge.
   assign fwd_a = BYPASS && wr_en && !reset && (writenum == readnum_a);
   assign fwd_b = BYPASS && wr_en && !reset && (writenum == readnum_b);

   // Storage: reset beats any write in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem[i] <= RESET_VAL;
         end
      end else if (wr_en) begin
         mem[writenum] <= data_in;
      end
   end

   // Read value per port: out-of-range addresses return zero.
   always_comb begin
      v_a = '0;
      v_b = '0;
      if (ra_ok) begin
         v_a = mem[readnum_a];
      end
      if (rb_ok) begin
         v_b = mem[readnum_b];
      end
      if (fwd_a) begin
         v_a = data_in;
      end
      if (fwd_b) begin
         v_b = data_in;
      end
   end

   if (READ_REG) begin : g_rd_reg
      logic [WIDTH-1:0] q_a;
      logic [WIDTH-1:0] q_b;

      // Registered read ports, latency one, cleared with the array.
      always_ff @(posedge clk) begin
         if (reset) begin
            q_a <= RESET_VAL;
            q_b <= RESET_VAL;
         end else begin
            q_a <= v_a;
            q_b <= v_b;
         end
      end

      assign data_out_a = q_a;
      assign data_out_b = q_b;
   end else begin : g_rd_comb
      assign data_out_a = v_a;
      assign data_out_b = v_b;
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: four builds (default, bypass with
// non-zero reset value, registered reads, six registers) share one stimulus.
module tb_regfile_2r1w;

   logic        clk;
   logic        reset;
   logic        write;
   logic [2:0]  writenum;
   logic [15:0] data_in;
   logic [2:0]  readnum_a;
   logic [2:0]  readnum_b;

   logic [15:0] base_a, base_b;
   logic [15:0] byp_a,  byp_b;
   logic [15:0] rr_a,   rr_b;
   logic [15:0] six_a,  six_b;

   int total;
   int bad;

   regfile_2r1w u_base (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(base_a), .data_out_b(base_b));

   regfile_2r1w #(.RESET_VAL(16'hA5A5), .BYPASS(1'b1)) u_byp (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(byp_a), .data_out_b(byp_b));

   regfile_2r1w #(.READ_REG(1'b1)) u_rr (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(rr_a), .data_out_b(rr_b));

   regfile_2r1w #(.NUM_REGS(6)) u_six (
      .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(six_a), .data_out_b(six_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      write = 1'b1;
      writenum = 3'd1;
      data_in = 16'h1111;
      tick();
      tick();
      reset = 1'b0;
      write = 1'b0;
      for (int i = 0; i < 8; i++) begin
         readnum_a = 3'(i);
         readnum_b = 3'(7 - i);
         tick();
         total += 8;
         if (base_a !== 16'h0000) begin bad++; $display("FAIL reset_base_a[%0d] got %h want 0000", i, base_a); end
         if (base_b !== 16'h0000) begin bad++; $display("FAIL reset_base_b[%0d] got %h want 0000", i, base_b); end
         if (byp_a !== 16'hA5A5) begin bad++; $display("FAIL reset_byp_a[%0d] got %h want a5a5", i, byp_a); end
         if (byp_b !== 16'hA5A5) begin bad++; $display("FAIL reset_byp_b[%0d] got %h want a5a5", i, byp_b); end
         if (rr_a !== 16'h0000) begin bad++; $display("FAIL reset_rr_a[%0d] got %h want 0000", i, rr_a); end
         if (rr_b !== 16'h0000) begin bad++; $display("FAIL reset_rr_b[%0d] got %h want 0000", i, rr_b); end
         if (six_a !== 16'h0000) begin bad++; $display("FAIL reset_six_a[%0d] got %h want 0000", i, six_a); end
         if (six_b !== 16'h0000) begin bad++; $display("FAIL reset_six_b[%0d] got %h want 0000", i, six_b); end
      end
   endtask

   task automatic test_write();
      logic [2:0] others [6];
      others = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
      write = 1'b1;
      writenum = 3'd3;
      data_in = 16'h1234;
      tick();
      writenum = 3'd7;
      data_in = 16'hBEEF;
      tick();
      write = 1'b0;
      writenum = 3'd1;
      data_in = 16'hDEAD;
      readnum_a = 3'd3;
      readnum_b = 3'd7;
      tick();
      total += 8;
      if (base_a !== 16'h1234) begin bad++; $display("FAIL write_base_a got %h want 1234", base_a); end
      if (base_b !== 16'hBEEF) begin bad++; $display("FAIL write_base_b got %h want beef", base_b); end
      if (byp_a !== 16'h1234) begin bad++; $display("FAIL write_byp_a got %h want 1234", byp_a); end
      if (byp_b !== 16'hBEEF) begin bad++; $display("FAIL write_byp_b got %h want beef", byp_b); end
      if (rr_a !== 16'h1234) begin bad++; $display("FAIL write_rr_a got %h want 1234", rr_a); end
      if (rr_b !== 16'hBEEF) begin bad++; $display("FAIL write_rr_b got %h want beef", rr_b); end
      if (six_a !== 16'h1234) begin bad++; $display("FAIL write_six_a got %h want 1234", six_a); end
      if (six_b !== 16'h0000) begin bad++; $display("FAIL write_six_oor_b got %h want 0000", six_b); end
      for (int i = 0; i < 6; i++) begin
         readnum_a = others[i];
         readnum_b = others[i];
         #1;
         total += 5;
         if (base_a !== 16'h0000) begin bad++; $display("FAIL untouched_base_a[%0d] got %h want 0000", others[i], base_a); end
         if (base_b !== base_a) begin bad++; $display("FAIL same_addr_base_b[%0d] got %h want %h", others[i], base_b, base_a); end
         if (byp_a !== 16'hA5A5) begin bad++; $display("FAIL untouched_byp_a[%0d] got %h want a5a5", others[i], byp_a); end
         if (byp_b !== 16'hA5A5) begin bad++; $display("FAIL untouched_byp_b[%0d] got %h want a5a5", others[i], byp_b); end
         if (six_a !== 16'h0000) begin bad++; $display("FAIL untouched_six_a[%0d] got %h want 0000", others[i], six_a); end
      end
      readnum_a = 3'd1;
      #1;
      total++;
      if (base_a !== 16'h0000) begin bad++; $display("FAIL write0_base_a got %h want 0000", base_a); end
   endtask

   task automatic test_bypass();
      write = 1'b1;
      writenum = 3'd5;
      data_in = 16'h0042;
      tick();
      readnum_a = 3'd5;
      readnum_b = 3'd5;
      data_in = 16'h00FF;
      #1;
      total += 4;
      if (base_a !== 16'h0042) begin bad++; $display("FAIL nobypass_base_a got %h want 0042", base_a); end
      if (byp_a !== 16'h00FF) begin bad++; $display("FAIL bypass_byp_a got %h want 00ff", byp_a); end
      if (byp_b !== 16'h00FF) begin bad++; $display("FAIL bypass_byp_b got %h want 00ff", byp_b); end
      if (six_a !== 16'h0042) begin bad++; $display("FAIL nobypass_six_a got %h want 0042", six_a); end
      tick();
      write = 1'b0;
      #1;
      total += 4;
      if (base_a !== 16'h00FF) begin bad++; $display("FAIL next_base_a got %h want 00ff", base_a); end
      if (byp_a !== 16'h00FF) begin bad++; $display("FAIL next_byp_a got %h want 00ff", byp_a); end
      if (rr_a !== 16'h0042) begin bad++; $display("FAIL rr_collide_a got %h want 0042", rr_a); end
      if (six_a !== 16'h00FF) begin bad++; $display("FAIL next_six_a got %h want 00ff", six_a); end
      tick();
      total++;
      if (rr_a !== 16'h00FF) begin bad++; $display("FAIL rr_after_a got %h want 00ff", rr_a); end
   endtask

   task automatic test_read_reg();
      readnum_b = 3'd3;
      tick();
      total++;
      if (rr_b !== 16'h1234) begin bad++; $display("FAIL rr_b3 got %h want 1234", rr_b); end
      readnum_b = 3'd7;
      #1;
      total += 2;
      if (rr_b !== 16'h1234) begin bad++; $display("FAIL rr_hold_b got %h want 1234", rr_b); end
      if (base_b !== 16'hBEEF) begin bad++; $display("FAIL comb_b7 got %h want beef", base_b); end
      tick();
      total++;
      if (rr_b !== 16'hBEEF) begin bad++; $display("FAIL rr_b7 got %h want beef", rr_b); end
   endtask

   task automatic test_reset_collision();
      readnum_a = 3'd2;
      readnum_b = 3'd3;
      tick();
      reset = 1'b1;
      write = 1'b1;
      writenum = 3'd2;
      data_in = 16'hFFFF;
      #1;
      total++;
      if (byp_a !== 16'hA5A5) begin bad++; $display("FAIL reset_nofwd_byp_a got %h want a5a5", byp_a); end
      tick();
      reset = 1'b0;
      write = 1'b0;
      #1;
      total += 7;
      if (rr_a !== 16'h0000) begin bad++; $display("FAIL rst_rr_a got %h want 0000", rr_a); end
      if (rr_b !== 16'h0000) begin bad++; $display("FAIL rst_rr_b got %h want 0000", rr_b); end
      if (base_a !== 16'h0000) begin bad++; $display("FAIL rst_base_r2 got %h want 0000", base_a); end
      if (base_b !== 16'h0000) begin bad++; $display("FAIL rst_base_r3 got %h want 0000", base_b); end
      if (byp_a !== 16'hA5A5) begin bad++; $display("FAIL rst_byp_r2 got %h want a5a5", byp_a); end
      if (byp_b !== 16'hA5A5) begin bad++; $display("FAIL rst_byp_r3 got %h want a5a5", byp_b); end
      if (six_b !== 16'h0000) begin bad++; $display("FAIL rst_six_r3 got %h want 0000", six_b); end
      readnum_a = 3'd5;
      readnum_b = 3'd7;
      #1;
      total += 2;
      if (base_a !== 16'h0000) begin bad++; $display("FAIL rst_base_r5 got %h want 0000", base_a); end
      if (base_b !== 16'h0000) begin bad++; $display("FAIL rst_base_r7 got %h want 0000", base_b); end
   endtask

   task automatic test_out_of_range();
      write = 1'b1;
      writenum = 3'd5;
      data_in = 16'h5555;
      tick();
      writenum = 3'd6;
      data_in = 16'h7777;
      tick();
      write = 1'b0;
      readnum_a = 3'd6;
      readnum_b = 3'd5;
      #1;
      total += 3;
      if (six_a !== 16'h0000) begin bad++; $display("FAIL oor_six_a got %h want 0000", six_a); end
      if (six_b !== 16'h5555) begin bad++; $display("FAIL oor_six_r5 got %h want 5555", six_b); end
      if (base_a !== 16'h7777) begin bad++; $display("FAIL inrange_base_r6 got %h want 7777", base_a); end
      for (int i = 0; i < 5; i++) begin
         readnum_a = 3'(i);
         #1;
         total++;
         if (six_a !== 16'h0000) begin bad++; $display("FAIL oor_six_r%0d got %h want 0000", i, six_a); end
      end
      write = 1'b1;
      writenum = 3'd6;
      data_in = 16'h0BAD;
      readnum_b = 3'd6;
      #1;
      total += 2;
      if (byp_b !== 16'h0BAD) begin bad++; $display("FAIL byp_fwd_r6 got %h want 0bad", byp_b); end
      if (six_b !== 16'h0000) begin bad++; $display("FAIL six_oor_rd6 got %h want 0000", six_b); end
      tick();
      write = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b0;
      write = 1'b0;
      writenum = '0;
      data_in = '0;
      readnum_a = '0;
      readnum_b = '0;
      test_reset();
      test_write();
      test_bypass();
      test_read_reg();
      test_reset_collision();
      test_out_of_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
